// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: sequences pipelined 8-word block fills and write-through stores to word memory
module cache_fill_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int LW = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_out,
  output logic                  mem_en,
  output logic                  mem_wr,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  fill_we,
  output logic [LW-1:0]         fill_word,
  output logic [15:0]           fill_data,
  output logic                  fill_tag_we,
  output logic                  fill_done,
  output logic                  wr_done,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state;
  logic [LW:0] issue_cnt, recv_cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic issuing, accept, writing;
  // counters stop at exactly WORDS_PER_BLOCK, so the top bit marks "all issued/received"
  always_comb begin
    issuing = !rst && state == FILL && !issue_cnt[LW];
    accept = !rst && state == FILL && mem_rvalid && !recv_cnt[LW];
    writing = !rst && state == WRITE;
    mem_en = issuing || writing;
    mem_wr = writing;
    mem_addr = issuing ? (base | {{(ADDR_WIDTH-LW-1){1'b0}}, issue_cnt[LW-1:0], 1'b0}) :
               writing ? {wr_addr[ADDR_WIDTH-1:1], 1'b0} : '0;
    mem_data_out = writing ? wr_data : '0;
    fill_we = accept;
    fill_word = accept ? recv_cnt[LW-1:0] : '0;
    fill_data = accept ? mem_rdata : '0;
    fill_done = !rst && state == DONE;
    fill_tag_we = fill_done;
    wr_done = writing;
    busy = !rst && state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      issue_cnt <= '0;
      recv_cnt <= '0;
      base <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            state <= FILL;
            base <= {miss_addr[ADDR_WIDTH-1:LW+1], {(LW+1){1'b0}}};
          end else if (wr_req) state <= WRITE;
        end
        FILL: begin
          if (issuing) issue_cnt <= issue_cnt + 1'b1;
          if (accept) begin
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt[LW-1:0] == '1) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          issue_cnt <= '0;
          recv_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
